// File: rtl/match_pkg.sv
// Shared types and constants for the match controller slice.
// State encoding, WINNER codes and datapath widths.
package match_pkg;

  localparam int ACT_W = 6;
  localparam int HP_W  = 2;
  localparam int POS_W = 3;

  typedef enum logic [POS_W-1:0] {
    S_IDLE   = 3'd0,
    S_CD     = 3'd1,
    S_FIGHT  = 3'd2,
    S_REND   = 3'd3,
    S_MEND   = 3'd4,
    S_PAUSED = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    W_NONE = 2'b00,
    W_P1   = 2'b01,
    W_P2   = 2'b10,
    W_DRAW = 2'b11
  } winner_e;

  function automatic logic is_onehot(
    input logic [ACT_W-1:0] v
  );
    return (v != '0) &&
           ((v & (v - ACT_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/match_if.sv
// Player/Game bus between the match controller and Game.
// master = controller side, slave = Game/stimulus side.
interface match_if;
  import match_pkg::*;

  logic [ACT_W-1:0] P1_IN;
  logic [ACT_W-1:0] P2_IN;
  logic [HP_W-1:0]  HP1;
  logic [HP_W-1:0]  HP2;
  logic [ACT_W-1:0] P1_ACT;
  logic [ACT_W-1:0] P2_ACT;
  logic             GAME_RST;

  modport master (
    input  P1_IN, P2_IN, HP1, HP2,
    output P1_ACT, P2_ACT, GAME_RST
  );

  modport slave (
    output P1_IN, P2_IN, HP1, HP2,
    input  P1_ACT, P2_ACT, GAME_RST
  );

endinterface

// File: rtl/round_timer.sv
// Loadable down-counter; expire flags the last enabled tick.
// Load wins over count; the counter stops at zero.
module round_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         expire
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (en && cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count  = cnt_q;
  assign expire = en && (cnt_q == W'(1));

endmodule

// File: rtl/match_controller.sv
// Best-of-N match sequencer in front of Game.
// Optional pause support: define MATCH_PAUSE_EN.
module match_controller
  import match_pkg::*;
#(
  parameter int ROUND_TICKS      = 64,
  parameter int COUNTDOWN_CYCLES = 4,
  parameter int END_HOLD         = 4,
  parameter int WINS_NEEDED      = 2,
  parameter int MAX_ROUNDS       = 5
) (
  input  logic CLK,
  input  logic RST,
  input  logic START,
`ifdef MATCH_PAUSE_EN
  input  logic PAUSE,
`endif
  match_if.master gi,
  output logic [POS_W-1:0] STATE,
  output logic [$clog2(ROUND_TICKS+1)-1:0] TIMER,
  output logic [POS_W-1:0] ROUND_NUM,
  output logic [1:0] P1_WINS,
  output logic [1:0] P2_WINS,
  output logic [1:0] WINNER,
  output logic       MATCH_DONE
);

  localparam int TW = $clog2(ROUND_TICKS+1);
  localparam int CW = $clog2(COUNTDOWN_CYCLES+1);
  localparam int EW = $clog2(END_HOLD+1);
  localparam int PW = (CW > EW) ? CW : EW;

  state_e state_q, state_d;

  logic          pause_rise;
  logic [TW-1:0] ft_cnt;
  logic          ft_load, ft_en, ft_exp;
  logic [PW-1:0] ph_cnt_unused, ph_val;
  logic          ph_load, ph_en, ph_exp;

  logic hp1z, hp2z, ko;
  logic decide, r_p1, r_p2;
  logic start_ok, over;

  logic [1:0]       p1w_q, p1w_d;
  logic [1:0]       p2w_q, p2w_d;
  logic [POS_W-1:0] rnd_q, rnd_d;
  winner_e          win_q, win_d;

`ifdef MATCH_PAUSE_EN
  logic pause_q;
  always_ff @(posedge CLK) begin
    if (RST) pause_q <= 1'b0;
    else     pause_q <= PAUSE;
  end
  assign pause_rise = PAUSE & ~pause_q;
`else
  assign pause_rise = 1'b0;
`endif

  assign hp1z = (gi.HP1 == '0);
  assign hp2z = (gi.HP2 == '0);
  assign ko   = hp1z | hp2z;

  // A pause edge outranks KO/time-out so the round resumes untouched.
  assign ft_en   = (state_q == S_FIGHT) && !ko && !pause_rise;
  assign ft_load = (state_q == S_CD) && ph_exp;

  assign decide = (state_q == S_FIGHT) && !pause_rise &&
                  (ko || ft_exp);
  assign r_p1 = (hp2z && !hp1z) ||
                (!ko && ft_exp && gi.HP1 > gi.HP2);
  assign r_p2 = (hp1z && !hp2z) ||
                (!ko && ft_exp && gi.HP2 > gi.HP1);

  assign start_ok = START &&
                    (state_q == S_IDLE || state_q == S_MEND);
  assign over = (p1w_q == 2'(WINS_NEEDED)) ||
                (p2w_q == 2'(WINS_NEEDED)) ||
                (rnd_q == POS_W'(MAX_ROUNDS));

  assign ph_en   = (state_q == S_CD) || (state_q == S_REND);
  assign ph_load = (state_d != state_q) &&
                   (state_d == S_CD || state_d == S_REND);
  assign ph_val  = (state_d == S_CD) ? PW'(COUNTDOWN_CYCLES)
                                     : PW'(END_HOLD);

  round_timer #(.W(TW)) u_fight (
    .clk      (CLK),
    .rst      (RST),
    .load     (ft_load),
    .load_val (TW'(ROUND_TICKS)),
    .en       (ft_en),
    .count    (ft_cnt),
    .expire   (ft_exp)
  );

  round_timer #(.W(PW)) u_phase (
    .clk      (CLK),
    .rst      (RST),
    .load     (ph_load),
    .load_val (ph_val),
    .en       (ph_en),
    .count    (ph_cnt_unused),
    .expire   (ph_exp)
  );

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_CD;
      S_CD:    if (ph_exp) state_d = S_FIGHT;
      S_FIGHT: begin
        if (pause_rise)  state_d = S_PAUSED;
        else if (decide) state_d = S_REND;
      end
      S_REND:  if (ph_exp) state_d = over ? S_MEND : S_CD;
      S_MEND:  if (start_ok) state_d = S_CD;
`ifdef MATCH_PAUSE_EN
      S_PAUSED: if (pause_rise) state_d = S_FIGHT;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gi.P1_ACT   = '0;
    gi.P2_ACT   = '0;
    gi.GAME_RST = 1'b1;
    MATCH_DONE  = 1'b0;
    case (state_q)
      S_FIGHT: begin
        gi.GAME_RST = 1'b0;
        if (is_onehot(gi.P1_IN)) gi.P1_ACT = gi.P1_IN;
        if (is_onehot(gi.P2_IN)) gi.P2_ACT = gi.P2_IN;
      end
`ifdef MATCH_PAUSE_EN
      S_PAUSED: gi.GAME_RST = 1'b0;
`endif
      S_MEND:  MATCH_DONE = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    p1w_d = p1w_q;
    p2w_d = p2w_q;
    rnd_d = rnd_q;
    win_d = win_q;
    if (start_ok) begin
      p1w_d = '0;
      p2w_d = '0;
      rnd_d = POS_W'(1);
      win_d = W_NONE;
    end else if (decide) begin
      if (r_p1 && p1w_q != 2'd3) p1w_d = p1w_q + 2'd1;
      if (r_p2 && p2w_q != 2'd3) p2w_d = p2w_q + 2'd1;
    end else if (state_q == S_REND && ph_exp) begin
      if (!over)
        rnd_d = rnd_q + POS_W'(1);
      else if (p1w_q > p2w_q)
        win_d = W_P1;
      else if (p2w_q > p1w_q)
        win_d = W_P2;
      else
        win_d = W_DRAW;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      p1w_q <= '0;
      p2w_q <= '0;
      rnd_q <= '0;
      win_q <= W_NONE;
    end else begin
      p1w_q <= p1w_d;
      p2w_q <= p2w_d;
      rnd_q <= rnd_d;
      win_q <= win_d;
    end
  end

  assign STATE     = state_q;
  assign TIMER     = ft_cnt;
  assign ROUND_NUM = rnd_q;
  assign P1_WINS   = p1w_q;
  assign P2_WINS   = p2w_q;
  assign WINNER    = win_q;

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller (small timing parameters).
// Define MATCH_PAUSE_EN to also exercise the pause feature.
module tb_match_controller;

  logic CLK = 1'b0;
  logic RST;
  logic START;
`ifdef MATCH_PAUSE_EN
  logic PAUSE;
`endif
  logic [2:0] STATE;
  logic [3:0] TIMER;
  logic [2:0] ROUND_NUM;
  logic [1:0] P1_WINS, P2_WINS, WINNER;
  logic       MATCH_DONE;

  int checks = 0;
  int failures = 0;

  match_if g();

  match_controller #(
    .ROUND_TICKS(8), .COUNTDOWN_CYCLES(3),
    .END_HOLD(2), .WINS_NEEDED(2), .MAX_ROUNDS(5)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START),
`ifdef MATCH_PAUSE_EN
    .PAUSE(PAUSE),
`endif
    .gi(g), .STATE(STATE), .TIMER(TIMER),
    .ROUND_NUM(ROUND_NUM), .P1_WINS(P1_WINS),
    .P2_WINS(P2_WINS), .WINNER(WINNER),
    .MATCH_DONE(MATCH_DONE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic start_to_fight();
    START = 1'b1; step();
    START = 1'b0; step(3);
  endtask

  task automatic test_reset();
    RST = 1'b1; START = 1'b0;
    g.P1_IN = 6'b010000; g.P2_IN = 6'b000001;
    g.HP1 = 2'd3; g.HP2 = 2'd3;
`ifdef MATCH_PAUSE_EN
    PAUSE = 1'b0;
`endif
    step(2);
    checks++; if (STATE !== 3'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", STATE); end
    checks++; if (g.GAME_RST !== 1'b1) begin failures++; $display("FAIL rst_game_rst got=%0b exp=1", g.GAME_RST); end
    checks++; if (TIMER !== 4'd0) begin failures++; $display("FAIL rst_timer got=%0d exp=0", TIMER); end
    checks++; if (ROUND_NUM !== 3'd0) begin failures++; $display("FAIL rst_round got=%0d exp=0", ROUND_NUM); end
    checks++; if ({P1_WINS, P2_WINS, WINNER} !== 6'd0) begin failures++; $display("FAIL rst_wins got=%b exp=0", {P1_WINS, P2_WINS, WINNER}); end
    checks++; if (MATCH_DONE !== 1'b0) begin failures++; $display("FAIL rst_done got=%0b exp=0", MATCH_DONE); end
    checks++; if ({g.P1_ACT, g.P2_ACT} !== 12'd0) begin failures++; $display("FAIL rst_acts got=%b exp=0", {g.P1_ACT, g.P2_ACT}); end
    RST = 1'b0;
  endtask

  task automatic test_countdown_gating();
    START = 1'b1; step(); START = 1'b0;
    checks++; if (STATE !== 3'd1 || ROUND_NUM !== 3'd1) begin failures++; $display("FAIL cd_enter got=%0d/%0d exp=1/1", STATE, ROUND_NUM); end
    step(2);
    checks++; if (STATE !== 3'd1 || g.GAME_RST !== 1'b1) begin failures++; $display("FAIL cd_third got=%0d/%0b exp=1/1", STATE, g.GAME_RST); end
    checks++; if (g.P1_ACT !== 6'd0) begin failures++; $display("FAIL cd_act got=%b exp=0", g.P1_ACT); end
    step();
    checks++; if (STATE !== 3'd2 || TIMER !== 4'd8) begin failures++; $display("FAIL fight_enter got=%0d/%0d exp=2/8", STATE, TIMER); end
    checks++; if (g.GAME_RST !== 1'b0) begin failures++; $display("FAIL fight_game_rst got=%0b exp=0", g.GAME_RST); end
    checks++; if (g.P1_ACT !== 6'b010000 || g.P2_ACT !== 6'b000001) begin failures++; $display("FAIL act_onehot got=%b/%b exp=010000/000001", g.P1_ACT, g.P2_ACT); end
    g.P1_IN = 6'b010010; g.P2_IN = 6'b000000; #1;
    checks++; if (g.P1_ACT !== 6'd0 || g.P2_ACT !== 6'd0) begin failures++; $display("FAIL act_multihot got=%b/%b exp=0/0", g.P1_ACT, g.P2_ACT); end
    g.P1_IN = 6'd0;
  endtask

  task automatic test_ko_match();
    step(2); g.HP2 = 2'd0; step(); g.HP2 = 2'd3;
    checks++; if (STATE !== 3'd3 || P1_WINS !== 2'd1 || P2_WINS !== 2'd0) begin failures++; $display("FAIL ko1 got=%0d/%0d/%0d exp=3/1/0", STATE, P1_WINS, P2_WINS); end
    checks++; if (TIMER !== 4'd6) begin failures++; $display("FAIL ko1_timer_hold got=%0d exp=6", TIMER); end
    step();
    checks++; if (STATE !== 3'd3) begin failures++; $display("FAIL rend_hold got=%0d exp=3", STATE); end
    step();
    checks++; if (STATE !== 3'd1 || ROUND_NUM !== 3'd2) begin failures++; $display("FAIL next_round got=%0d/%0d exp=1/2", STATE, ROUND_NUM); end
    step(3); g.HP2 = 2'd0; step(); g.HP2 = 2'd3;
    checks++; if (P1_WINS !== 2'd2) begin failures++; $display("FAIL ko2 got=%0d exp=2", P1_WINS); end
    step(2);
    checks++; if (STATE !== 3'd4 || WINNER !== 2'b01 || MATCH_DONE !== 1'b1) begin failures++; $display("FAIL ko_mend got=%0d/%b/%0b exp=4/01/1", STATE, WINNER, MATCH_DONE); end
  endtask

  task automatic test_timeout();
    int n;
    g.HP1 = 2'd3; g.HP2 = 2'd2;
    start_to_fight();
    checks++; if (P1_WINS !== 2'd0 || ROUND_NUM !== 3'd1 || WINNER !== 2'b00) begin failures++; $display("FAIL restart got=%0d/%0d/%b exp=0/1/00", P1_WINS, ROUND_NUM, WINNER); end
    n = 0;
    while (STATE == 3'd2 && n < 20) begin n++; step(); end
    checks++; if (n !== 8) begin failures++; $display("FAIL to_len got=%0d exp=8", n); end
    checks++; if (P1_WINS !== 2'd1 || TIMER !== 4'd0) begin failures++; $display("FAIL to_p1 got=%0d/%0d exp=1/0", P1_WINS, TIMER); end
    g.HP2 = 2'd3;
    step(2); step(3); step(8);
    checks++; if (STATE !== 3'd3 || P1_WINS !== 2'd1 || P2_WINS !== 2'd0) begin failures++; $display("FAIL to_draw got=%0d/%0d/%0d exp=3/1/0", STATE, P1_WINS, P2_WINS); end
    step(2);
    checks++; if (ROUND_NUM !== 3'd3) begin failures++; $display("FAIL to_round got=%0d exp=3", ROUND_NUM); end
    step(3); g.HP1 = 2'd0; step(); g.HP1 = 2'd3;
    checks++; if (P2_WINS !== 2'd1 || P1_WINS !== 2'd1) begin failures++; $display("FAIL ko_p2 got=%0d/%0d exp=1/1", P2_WINS, P1_WINS); end
  endtask

  task automatic test_draws();
    RST = 1'b1; step(); RST = 1'b0;
    g.HP1 = 2'd3; g.HP2 = 2'd3;
    start_to_fight();
    g.HP1 = 2'd0; g.HP2 = 2'd0; step();
    checks++; if (STATE !== 3'd3 || {P1_WINS, P2_WINS} !== 4'd0) begin failures++; $display("FAIL dko got=%0d/%b exp=3/0000", STATE, {P1_WINS, P2_WINS}); end
    g.HP1 = 2'd3; g.HP2 = 2'd3;
    step(2); step(3); step(7);
    checks++; if (STATE !== 3'd2 || TIMER !== 4'd1) begin failures++; $display("FAIL last_tick got=%0d/%0d exp=2/1", STATE, TIMER); end
    g.HP1 = 2'd0; g.HP2 = 2'd0; step();
    checks++; if (STATE !== 3'd3 || {P1_WINS, P2_WINS} !== 4'd0 || TIMER !== 4'd1) begin failures++; $display("FAIL dko_last got=%0d/%b/%0d exp=3/0000/1", STATE, {P1_WINS, P2_WINS}, TIMER); end
    for (int r = 3; r <= 5; r++) begin
      step(2); step(3); step();
    end
    checks++; if (STATE !== 3'd3 || ROUND_NUM !== 3'd5) begin failures++; $display("FAIL draw5 got=%0d/%0d exp=3/5", STATE, ROUND_NUM); end
    step(2);
    checks++; if (STATE !== 3'd4 || WINNER !== 2'b11 || MATCH_DONE !== 1'b1) begin failures++; $display("FAIL draw_mend got=%0d/%b/%0b exp=4/11/1", STATE, WINNER, MATCH_DONE); end
    g.HP1 = 2'd3; g.HP2 = 2'd3;
  endtask

  task automatic test_abort();
    RST = 1'b1; step(); RST = 1'b0;
    start_to_fight();
    START = 1'b1; step(); START = 1'b0;
    checks++; if (STATE !== 3'd2 || TIMER !== 4'd7 || ROUND_NUM !== 3'd1) begin failures++; $display("FAIL start_ign got=%0d/%0d/%0d exp=2/7/1", STATE, TIMER, ROUND_NUM); end
    step(3);
    checks++; if (TIMER !== 4'd4) begin failures++; $display("FAIL pre_abort got=%0d exp=4", TIMER); end
    RST = 1'b1; step(); RST = 1'b0;
    checks++; if (STATE !== 3'd0 || g.GAME_RST !== 1'b1 || TIMER !== 4'd0) begin failures++; $display("FAIL abort got=%0d/%0b/%0d exp=0/1/0", STATE, g.GAME_RST, TIMER); end
    checks++; if (ROUND_NUM !== 3'd0 || MATCH_DONE !== 1'b0) begin failures++; $display("FAIL abort_regs got=%0d/%0b exp=0/0", ROUND_NUM, MATCH_DONE); end
  endtask

`ifdef MATCH_PAUSE_EN
  task automatic test_pause();
    start_to_fight(); step(3);
    g.P1_IN = 6'b010000;
    PAUSE = 1'b1; step();
    checks++; if (STATE !== 3'd5 || TIMER !== 4'd5) begin failures++; $display("FAIL pause got=%0d/%0d exp=5/5", STATE, TIMER); end
    checks++; if (g.P1_ACT !== 6'd0 || g.GAME_RST !== 1'b0) begin failures++; $display("FAIL pause_out got=%b/%0b exp=0/0", g.P1_ACT, g.GAME_RST); end
    PAUSE = 1'b0; step();
    checks++; if (STATE !== 3'd5 || TIMER !== 4'd5) begin failures++; $display("FAIL pause_hold got=%0d/%0d exp=5/5", STATE, TIMER); end
    PAUSE = 1'b1; step(); PAUSE = 1'b0; step();
    checks++; if (STATE !== 3'd2 || TIMER !== 4'd4) begin failures++; $display("FAIL resume got=%0d/%0d exp=2/4", STATE, TIMER); end
    g.P1_IN = 6'd0;
  endtask
`endif

  initial begin
    test_reset();
    test_countdown_gating();
    test_ko_match();
    test_timeout();
    test_draws();
    test_abort();
`ifdef MATCH_PAUSE_EN
    test_pause();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
